// File: rtl/bcd_updown_counter_if.sv
// Control and status bundle between a BCD counter and its user.
// Pure wiring, no latency of its own.
// No backpressure: the master drives controls and the slave reports every cycle.
interface bcd_updown_counter_if #(
    parameter int DIGITS = 4
);
    logic                  en;
    logic                  up;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic [4*DIGITS-1:0]   count;
    logic                  tc;
    logic                  zero;
    logic                  load_err;

    modport master (
        output en, up, load, load_val,
        input  count, tc, zero, load_err
    );

    modport slave (
        input  en, up, load, load_val,
        output count, tc, zero, load_err
    );
endinterface

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with sanitising preset load and wrap or saturate at the ends.
// One clk from an enabled or load edge to the new count; zero is combinational from the count register.
// No backpressure: at most one step per clk while en is high, load always wins over en.
module bcd_updown_counter #(
    parameter int                  DIGITS      = 4,
    parameter bit                  WRAP        = 1'b1,
    parameter logic [4*DIGITS-1:0] RESET_VALUE = '0
) (
    input  logic                clk,
    input  logic                rst,
    bcd_updown_counter_if.slave bus
);

    localparam int W = 4 * DIGITS;

    logic [W-1:0] count_q, count_d;
    logic         tc_q, tc_d;
    logic         load_err_q, load_err_d;

    logic [W-1:0] load_san;
    logic         load_bad;
    logic [W-1:0] count_inc, count_dec;
    logic         carry, borrow;
    logic         all_nine, all_zero;

    // Clamp every preset nibble above 9 down to 9 and remember that one was bad.
    always_comb begin
        load_san = '0;
        load_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.load_val[4*i +: 4] > 4'd9) begin
                load_san[4*i +: 4] = 4'd9;
                load_bad           = 1'b1;
            end else begin
                load_san[4*i +: 4] = bus.load_val[4*i +: 4];
            end
        end
    end

    // Ripple carry and ripple borrow across digits; a carry/borrow out of the top digit marks the boundary.
    always_comb begin
        count_inc = '0;
        count_dec = '0;
        carry     = 1'b1;
        borrow    = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (count_q[4*i +: 4] == 4'd9) begin
                    count_inc[4*i +: 4] = 4'd0;
                end else begin
                    count_inc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                    carry               = 1'b0;
                end
            end else begin
                count_inc[4*i +: 4] = count_q[4*i +: 4];
            end

            if (borrow) begin
                if (count_q[4*i +: 4] == 4'd0) begin
                    count_dec[4*i +: 4] = 4'd9;
                end else begin
                    count_dec[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
                    borrow              = 1'b0;
                end
            end else begin
                count_dec[4*i +: 4] = count_q[4*i +: 4];
            end
        end
        all_nine = carry;
        all_zero = borrow;
    end

    // Next state: load beats en; at a boundary tc fires and the count either rolls (already in inc/dec) or holds.
    always_comb begin
        count_d    = count_q;
        tc_d       = 1'b0;
        load_err_d = 1'b0;
        if (bus.load) begin
            count_d    = load_san;
            load_err_d = load_bad;
        end else if (bus.en) begin
            if (bus.up) begin
                tc_d    = all_nine;
                count_d = (all_nine && !WRAP) ? count_q : count_inc;
            end else begin
                tc_d    = all_zero;
                count_d = (all_zero && !WRAP) ? count_q : count_dec;
            end
        end
    end

    // State registers; reset discards any step in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q    <= RESET_VALUE;
            tc_q       <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            tc_q       <= tc_d;
            load_err_q <= load_err_d;
        end
    end

    assign bus.count    = count_q;
    assign bus.tc       = tc_q;
    assign bus.load_err = load_err_q;
    assign bus.zero     = (count_q == '0);

endmodule

// File: doc/bcd_updown_counter.md
Name: bcd_updown_counter

Overview:
- Parametrised multi-digit BCD counter: the successor to the team's fixed 4-digit countdown.
- Adds up/down direction, count enable, parallel preset load with digit sanitising, and wrap or saturate mode.
- Adds a terminal-count pulse and a zero flag.
- Feeds the seven-segment display path (one 4-bit BCD nibble per digit) and the timer/stopwatch control logic.

Parameters:
- DIGITS, 4, number of BCD digits; legal range 1..8.
- WRAP, 1, 1 = roll over at the boundary (all-9 to all-0, or all-0 to all-9); 0 = saturate and hold at the boundary.
- RESET_VALUE, 0, packed BCD value loaded on reset; width 4*DIGITS; every nibble must be 0..9.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  count enable; one step per clk while high.
- up  input  1  direction: 1 = increment, 0 = decrement; sampled on each enabled step.
- load  input  1  synchronous preset load; takes priority over en.
- load_val  input  4*DIGITS  preset value, packed BCD, digit 0 in bits [3:0].
- count  output  4*DIGITS  current value, packed BCD, digit 0 in bits [3:0].
- tc  output  1  registered terminal-count pulse.
- zero  output  1  combinational flag: 1 when count is all zeros.
- load_err  output  1  registered pulse: the last load contained a nibble greater than 9.

Behaviour:
- Reset (rst high, asynchronous):
  - count = RESET_VALUE; tc = 0; load_err = 0.
  - Reset held high overrides load and en.
  - Reset asserted mid-step aborts the step; no partial carry survives.
  - First step happens on the first rising clk edge after rst deasserts.
- Priority per edge: rst > load > en > hold.
- Load:
  - count takes load_val in one cycle.
  - Any nibble greater than 9 is clamped to 9; all other nibbles load unchanged.
  - load_err = 1 on the next cycle if any nibble was clamped, else 0.
  - tc = 0 on a load cycle. en is ignored that cycle.
- Increment (en=1, up=1):
  - Digit 0 adds 1.
  - A digit at 9 becomes 0 and carries to the next digit; carry ripples through consecutive 9s.
  - The update is single-cycle; latency from the enabled edge to the new count is one clk.
- Decrement (en=1, up=0):
  - Digit 0 subtracts 1.
  - A digit at 0 becomes 9 and borrows from the next digit; borrow ripples through consecutive 0s.
- Boundary, up direction (count all-9 and an increment step is taken):
  - WRAP=1: count becomes all-0.
  - WRAP=0: count holds at all-9.
  - Either case: tc = 1 for exactly the next cycle.
- Boundary, down direction (count all-0 and a decrement step is taken):
  - WRAP=1: count becomes all-9.
  - WRAP=0: count holds at all-0.
  - Either case: tc = 1 for exactly the next cycle.
- tc:
  - 0 on every other cycle, including non-boundary steps and en=0 cycles.
  - With WRAP=0 and en held at the boundary, tc repeats every cycle; the consumer edge-detects if needed.
- Direction change: up may change on any cycle; each step uses the up value sampled on that edge. There is no pipeline state to flush.
- en=0: count, tc and load_err hold or clear as defined; count is unchanged.
- zero follows count combinationally, zero latency from the count register.
- Outputs never hold a nibble greater than 9 after reset or any operation.

Test Plan (DIGITS=4 unless noted):
1. Reset:
   - Stimulus: RESET_VALUE=0x0000; assert rst asynchronously mid-cycle while counting at 0x0057.
   - Required: count = 0x0000 immediately, without waiting for a clk edge; zero = 1; tc = 0.
2. Ripple carry:
   - Stimulus: load 0x0999, then en=1, up=1 for 1 clk.
   - Required: count = 0x1000, tc = 0.
   - Stimulus: load 0x1000, then en=1, up=0 for 1 clk.
   - Required: count = 0x0999.
3. Wrap (WRAP=1):
   - Stimulus: load 0x9999, then one up step.
   - Required: count = 0x0000, tc = 1 for one cycle.
   - Stimulus: then one down step.
   - Required: count = 0x9999, tc = 1.
4. Saturate (WRAP=0):
   - Stimulus: load 0x0000, up=0, en held 3 clks.
   - Required: count stays 0x0000; tc = 1 on each of the 3 following cycles; zero = 1.
5. Load sanitising and priority:
   - Stimulus: load_val = 0x3A5F with load=1 and en=1 in the same cycle.
   - Required: count = 0x3959; load_err = 1 for one cycle; no step is applied that cycle.
   - Stimulus: next cycle, with en=1 and up=1.
   - Required: count = 0x3960.
6. Direction change and hold:
   - Stimulus: from 0x0010, up=0 for 1 step.
   - Required: count = 0x0009.
   - Stimulus: up=1 for 1 step.
   - Required: count = 0x0010.
   - Stimulus: en=0 for 5 clks.
   - Required: count stays 0x0010, tc = 0.
   - Stimulus: repeat the full sequence with DIGITS=1 and DIGITS=8.
   - Required: same boundary behaviour at 9/0 and 99999999/00000000.
